// File: rtl/sm3_msg_padder.sv
// SM3 message padder: packs a byte stream into 512-bit blocks and appends
// the 0x80 marker, zero fill and 64-bit big-endian bit length.
module sm3_msg_padder #(
  parameter int LEN_W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  input  logic         in_last,
  output logic         in_ready,
  output logic [511:0] blk_data,
  output logic         blk_valid,
  input  logic         blk_ready,
  output logic         blk_first,
  output logic         blk_final,
  output logic         busy
);

  typedef enum logic [1:0] {
    FILL = 2'd0,
    PAD  = 2'd1,
    LEN  = 2'd2,
    OUT  = 2'd3
  } state_t;

  localparam logic [LEN_W-1:0] LEN_STEP  = LEN_W'(8);
  localparam logic [511:0]     BYTE_MASK = {504'd0, 8'hFF};

  // Overwrite byte idx (0 = most significant) of a block.
  function automatic logic [511:0] put_byte(input logic [511:0] blk,
                                            input logic [5:0]   idx,
                                            input logic [7:0]   b);
    logic [8:0] sh;
    sh = {6'd63 - idx, 3'b000};
    return (blk & ~(BYTE_MASK << sh)) | ({504'd0, b} << sh);
  endfunction

  state_t           state_r, state_s;
  logic [511:0]     buf_r, buf_s;
  logic [6:0]       cnt_r, cnt_s;
  logic [LEN_W-1:0] len_r, len_s;
  logic             sent_r, sent_s;
  logic             final_r, final_s;
  logic             first_r, first_s;
  logic             owe_r, owe_s;
  logic             marker_r, marker_s;
  logic             busy_r, busy_s;
  logic             valid_r, valid_s;
  logic             ready_r, ready_s;
  logic             accept_s;
  logic [63:0]      len64_s;

  assign len64_s   = 64'(len_r);
  assign accept_s  = in_valid && ready_r;

  assign in_ready  = ready_r;
  assign blk_data  = buf_r;
  assign blk_valid = valid_r;
  assign blk_first = first_r;
  assign blk_final = final_r;
  assign busy      = busy_r;

  // Next-state and next-output logic for the padding FSM.
  always_comb begin
    state_s  = state_r;
    buf_s    = buf_r;
    cnt_s    = cnt_r;
    len_s    = len_r;
    sent_s   = sent_r;
    final_s  = final_r;
    first_s  = first_r;
    owe_s    = owe_r;
    marker_s = marker_r;
    busy_s   = busy_r;
    valid_s  = valid_r;
    ready_s  = ready_r;
    case (state_r)
      FILL: begin
        if (accept_s) begin
          buf_s  = put_byte(buf_r, cnt_r[5:0], in_data);
          cnt_s  = cnt_r + 7'd1;
          len_s  = len_r + LEN_STEP;
          busy_s = 1'b1;
          if (in_last) begin
            state_s = PAD;
            ready_s = 1'b0;
          end else if (cnt_r == 7'd63) begin
            state_s = OUT;
            ready_s = 1'b0;
            valid_s = 1'b1;
            final_s = 1'b0;
            first_s = !sent_r;
          end else begin
            state_s = FILL;
          end
        end else begin
          state_s = FILL;
        end
      end
      PAD: begin
        state_s = OUT;
        valid_s = 1'b1;
        first_s = !sent_r;
        final_s = 1'b0;
        if (cnt_r <= 7'd55) begin
          buf_s        = put_byte(buf_r, cnt_r[5:0], 8'h80);
          buf_s[63:0]  = len64_s;
          final_s      = 1'b1;
          owe_s        = 1'b0;
          marker_s     = 1'b0;
        end else if (cnt_r <= 7'd63) begin
          buf_s    = put_byte(buf_r, cnt_r[5:0], 8'h80);
          owe_s    = 1'b1;
          marker_s = 1'b0;
        end else begin
          // Block was completely full: the marker moves to the length block.
          owe_s    = 1'b1;
          marker_s = 1'b1;
        end
      end
      LEN: begin
        buf_s          = 512'd0;
        buf_s[511:504] = marker_r ? 8'h80 : 8'h00;
        buf_s[63:0]    = len64_s;
        final_s        = 1'b1;
        first_s        = !sent_r;
        owe_s          = 1'b0;
        marker_s       = 1'b0;
        valid_s        = 1'b1;
        state_s        = OUT;
      end
      OUT: begin
        if (blk_ready) begin
          valid_s = 1'b0;
          buf_s   = 512'd0;
          cnt_s   = 7'd0;
          sent_s  = 1'b1;
          first_s = 1'b0;
          final_s = 1'b0;
          if (owe_r) begin
            state_s = LEN;
            ready_s = 1'b0;
          end else begin
            state_s = FILL;
            ready_s = 1'b1;
          end
          if (final_r) begin
            busy_s = 1'b0;
            sent_s = 1'b0;
            len_s  = '0;
          end else begin
            busy_s = busy_r;
          end
        end else begin
          state_s = OUT;
        end
      end
      default: begin
        state_s = FILL;
        ready_s = 1'b1;
        valid_s = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= FILL;
      buf_r    <= 512'd0;
      cnt_r    <= 7'd0;
      len_r    <= '0;
      sent_r   <= 1'b0;
      final_r  <= 1'b0;
      first_r  <= 1'b0;
      owe_r    <= 1'b0;
      marker_r <= 1'b0;
      busy_r   <= 1'b0;
      valid_r  <= 1'b0;
      ready_r  <= 1'b1;
    end else begin
      state_r  <= state_s;
      buf_r    <= buf_s;
      cnt_r    <= cnt_s;
      len_r    <= len_s;
      sent_r   <= sent_s;
      final_r  <= final_s;
      first_r  <= first_s;
      owe_r    <= owe_s;
      marker_r <= marker_s;
      busy_r   <= busy_s;
      valid_r  <= valid_s;
      ready_r  <= ready_s;
    end
  end

endmodule

// File: doc/sm3_msg_padder.md
Name: sm3_msg_padder

Overview:
- Byte-stream front end for the SM3 compression core.
- Accepts message bytes with an end-of-message flag and packs them into 512-bit blocks.
- Applies SM3 padding to the last block(s): a 0x80 byte, then zero bytes, then the 64-bit big-endian message bit length.
- Sits between the AXI-Lite byte-write path and the compression engine, whose digests land in the result FIFO.

Parameters:
- LEN_W, 64, width of the internal bit-length counter (16..64). The value is zero-extended into the 64-bit length field.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- in_data  in  8  message byte
- in_valid  in  1  in_data valid
- in_last  in  1  in_data is the final byte of the message
- in_ready  out  1  padder can accept a byte this cycle
- blk_data  out  512  block; byte 0 of the block is in [511:504], word W0 is in [511:480]
- blk_valid  out  1  blk_data valid
- blk_ready  in  1  downstream accepts the block
- blk_first  out  1  block is the first block of a message
- blk_final  out  1  block is the last block of a message (the digest is taken after it)
- busy  out  1  a message is in progress (at least one byte accepted and final block not yet taken)

Behaviour:
- Reset is synchronous, active-high, on clk. Reset values: in_ready=1, blk_valid=0, blk_first=0, blk_final=0, busy=0, blk_data=0. Reset also clears the byte counter, the length counter and the first-block flag.
- Reset asserted mid-message or mid-output discards all partial state; no block is emitted. The next accepted byte starts a new message.
- A byte is accepted when in_valid && in_ready.
- Accepted bytes are written at byte position cnt (0..63), MSB-first. Each accept advances cnt by 1 and the bit length by 8. The bit length wraps modulo 2^LEN_W.
- States: FILL, PAD, LEN, OUT.
- FILL: in_ready=1.
  - Accept with cnt==63 and !in_last: go to OUT with final=0.
  - Accept with in_last: go to PAD.
- PAD: one cycle, in_ready=0. Let n = bytes held (1..64).
  - n<=55: byte n=0x80, bytes n+1..55 = 0, bytes 56..63 = length. Go to OUT with final=1.
  - 56<=n<=63: byte n=0x80, bytes n+1..63 = 0. Go to OUT with final=0; after that handshake, LEN.
  - n==64: go to OUT with final=0 unchanged; after that handshake, LEN with the 0x80 marker pending.
- LEN: one cycle. Builds a block of zeros with length in bytes 56..63; byte 0 is 0x80 if the marker is pending. Go to OUT with final=1.
- OUT: blk_valid=1, in_ready=0.
  - blk_data, blk_first and blk_final are held stable while blk_valid && !blk_ready.
  - On handshake: blk_valid=0 the next cycle and the buffer is cleared.
  - Next state: back to FILL if not final or if final (message done, busy=0), or to LEN if a second padding block is owed.
- blk_first=1 only on the first block emitted after a message start.
- Latency:
  - Full non-final block: blk_valid on the cycle after the 64th byte is accepted.
  - Final-byte accept: blk_valid two cycles after the accept (one PAD cycle).
  - Second padding block: blk_valid two cycles after the preceding handshake (one LEN cycle).
- No output double buffer. The input stalls for the whole of OUT; this throughput matches the compression core.
- Empty messages are not supported: every message has at least one byte.
- in_last is ignored when in_valid=0.

Test Plan:
- "abc" (0x61,0x62,0x63, last on 0x63), blk_ready=1 -> one block:
  - blk_data[511:480]=0x61626380
  - bits [479:64]=0
  - blk_data[63:0]=0x18
  - blk_first=1, blk_final=1, blk_valid 2 cycles after the last accept
- 55 bytes of 0xAA -> one block: byte 55=0x80, length=0x1B8, blk_final=1.
- 56 bytes of 0xAA -> two blocks:
  - Block 1: byte 56=0x80, bytes 57..63=0, final=0, first=1.
  - Block 2: all zero except [63:0]=0x1C0, final=1, first=0.
- 64 bytes "abcd"x16, last on byte 63 -> two blocks:
  - Block 1: raw data, final=0.
  - Block 2: [511:504]=0x80, [63:0]=0x200, final=1.
- Backpressure: hold blk_ready=0 for 10 cycles while in_valid=1 -> blk_data and flags stable, in_ready=0; no byte is lost or duplicated, checked against the reference digest via the SM3 core.
- Reset mid-message: 20 bytes, rst for 1 cycle, then "abc" -> the output equals the "abc" test exactly (first=1, length 0x18); no stale block appears.
